// File: rtl/ifft8_core.sv
// ifft8_core: 8-point radix-2 DIT inverse FFT built around one time-shared butterfly.
// Define IFFT8_SCALE_EN to halve every butterfly output (overall 1/8, the true IFFT).
module ifft8_core (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic signed [15:0] X_0_R_i,
    input  logic signed [15:0] X_0_I_i,
    input  logic signed [15:0] X_1_R_i,
    input  logic signed [15:0] X_1_I_i,
    input  logic signed [15:0] X_2_R_i,
    input  logic signed [15:0] X_2_I_i,
    input  logic signed [15:0] X_3_R_i,
    input  logic signed [15:0] X_3_I_i,
    input  logic signed [15:0] X_4_R_i,
    input  logic signed [15:0] X_4_I_i,
    input  logic signed [15:0] X_5_R_i,
    input  logic signed [15:0] X_5_I_i,
    input  logic signed [15:0] X_6_R_i,
    input  logic signed [15:0] X_6_I_i,
    input  logic signed [15:0] X_7_R_i,
    input  logic signed [15:0] X_7_I_i,
    output logic signed [15:0] x_0_R_o,
    output logic signed [15:0] x_0_I_o,
    output logic signed [15:0] x_1_R_o,
    output logic signed [15:0] x_1_I_o,
    output logic signed [15:0] x_2_R_o,
    output logic signed [15:0] x_2_I_o,
    output logic signed [15:0] x_3_R_o,
    output logic signed [15:0] x_3_I_o,
    output logic signed [15:0] x_4_R_o,
    output logic signed [15:0] x_4_I_o,
    output logic signed [15:0] x_5_R_o,
    output logic signed [15:0] x_5_I_o,
    output logic signed [15:0] x_6_R_o,
    output logic signed [15:0] x_6_I_o,
    output logic signed [15:0] x_7_R_o,
    output logic signed [15:0] x_7_I_o,
    output logic               valid_o,
    output logic               busy_o
);
    localparam int unsigned DW = 16;  // sample width
    localparam int unsigned AW = 18;  // butterfly sum width
    localparam int unsigned PW = 32;  // product width
    localparam int unsigned NB = 12;  // butterflies per transform

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t               state;
    logic [3:0]           cnt;
    logic signed [DW-1:0] in_r  [8];
    logic signed [DW-1:0] in_i  [8];
    logic signed [DW-1:0] rf_r  [8];
    logic signed [DW-1:0] rf_i  [8];
    logic signed [DW-1:0] out_r [8];
    logic signed [DW-1:0] out_i [8];

    assign in_r[0] = X_0_R_i;  assign in_i[0] = X_0_I_i;
    assign in_r[1] = X_1_R_i;  assign in_i[1] = X_1_I_i;
    assign in_r[2] = X_2_R_i;  assign in_i[2] = X_2_I_i;
    assign in_r[3] = X_3_R_i;  assign in_i[3] = X_3_I_i;
    assign in_r[4] = X_4_R_i;  assign in_i[4] = X_4_I_i;
    assign in_r[5] = X_5_R_i;  assign in_i[5] = X_5_I_i;
    assign in_r[6] = X_6_R_i;  assign in_i[6] = X_6_I_i;
    assign in_r[7] = X_7_R_i;  assign in_i[7] = X_7_I_i;

    assign x_0_R_o = out_r[0];  assign x_0_I_o = out_i[0];
    assign x_1_R_o = out_r[1];  assign x_1_I_o = out_i[1];
    assign x_2_R_o = out_r[2];  assign x_2_I_o = out_i[2];
    assign x_3_R_o = out_r[3];  assign x_3_I_o = out_i[3];
    assign x_4_R_o = out_r[4];  assign x_4_I_o = out_i[4];
    assign x_5_R_o = out_r[5];  assign x_5_I_o = out_i[5];
    assign x_6_R_o = out_r[6];  assign x_6_I_o = out_i[6];
    assign x_7_R_o = out_r[7];  assign x_7_I_o = out_i[7];

    function automatic logic [2:0] bitrev3(input logic [2:0] v);
        return {v[0], v[1], v[2]};
    endfunction

    // Optional halving, then clamp to the 16-bit signed range
    function automatic logic signed [DW-1:0] scale_sat(input logic signed [AW-1:0] v);
        logic signed [AW-1:0] s;
`ifdef IFFT8_SCALE_EN
        s = v >>> 1;
`else
        s = v;
`endif
        if (s > AW'(32767))
            return 16'sh7FFF;
        else if (s < AW'(-32768))
            return 16'sh8000;
        else
            return DW'(s);
    endfunction

    logic [1:0] stage;
    logic [1:0] pos;
    logic [1:0] tw;
    logic [2:0] idx_a;
    logic [2:0] idx_b;

    assign stage = cnt[3:2];
    assign pos   = cnt[1:0];

    // Butterfly pair addresses and twiddle index for the current counter value
    always_comb begin
        idx_a = {pos, 1'b0};
        idx_b = {pos, 1'b1};
        tw    = 2'd0;
        case (stage)
            2'd1: begin
                idx_a = {pos[1], 1'b0, pos[0]};
                idx_b = {pos[1], 1'b1, pos[0]};
                tw    = {pos[0], 1'b0};
            end
            2'd2: begin
                idx_a = {1'b0, pos};
                idx_b = {1'b1, pos};
                tw    = pos;
            end
            default: ;
        endcase
    end

    logic signed [DW-1:0] w_r;
    logic signed [DW-1:0] w_i;

    always_comb begin
        case (tw)
            2'd1:    begin w_r = 16'sd11585;  w_i = 16'sd11585; end
            2'd2:    begin w_r = 16'sd0;      w_i = 16'sd16384; end
            2'd3:    begin w_r = -16'sd11585; w_i = 16'sd11585; end
            default: begin w_r = 16'sd16384;  w_i = 16'sd0;     end
        endcase
    end

    logic signed [DW-1:0] a_r, a_i, b_r, b_i;
    logic signed [PW-1:0] p_rr, p_ii, p_ri, p_ir;
    logic signed [PW:0]   s_r, s_i;
    logic signed [AW-1:0] t_r, t_i, sum_r, sum_i, dif_r, dif_i;

    assign a_r = rf_r[idx_a];
    assign a_i = rf_i[idx_a];
    assign b_r = rf_r[idx_b];
    assign b_i = rf_i[idx_b];

    // t = b * W; unity twiddle bypasses the multipliers
    always_comb begin
        p_rr = PW'(b_r) * PW'(w_r);
        p_ii = PW'(b_i) * PW'(w_i);
        p_ri = PW'(b_r) * PW'(w_i);
        p_ir = PW'(b_i) * PW'(w_r);
        s_r  = (PW+1)'(p_rr) - (PW+1)'(p_ii);
        s_i  = (PW+1)'(p_ri) + (PW+1)'(p_ir);
        if (tw == 2'd0) begin
            t_r = AW'(b_r);
            t_i = AW'(b_i);
        end else begin
            t_r = AW'(s_r >>> 14);
            t_i = AW'(s_i >>> 14);
        end
        sum_r = AW'(a_r) + t_r;
        sum_i = AW'(a_i) + t_i;
        dif_r = AW'(a_r) - t_r;
        dif_i = AW'(a_i) - t_i;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            valid_o <= 1'b0;
            busy_o  <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                rf_r[i]  <= '0;
                rf_i[i]  <= '0;
                out_r[i] <= '0;
                out_i[i] <= '0;
            end
        end else begin
            valid_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        for (int i = 0; i < 8; i++) begin
                            rf_r[i] <= in_r[bitrev3(3'(i))];
                            rf_i[i] <= in_i[bitrev3(3'(i))];
                        end
                        cnt    <= '0;
                        busy_o <= 1'b1;
                        state  <= CALC;
                    end
                end
                CALC: begin
                    rf_r[idx_a] <= scale_sat(sum_r);
                    rf_i[idx_a] <= scale_sat(sum_i);
                    rf_r[idx_b] <= scale_sat(dif_r);
                    rf_i[idx_b] <= scale_sat(dif_i);
                    if (cnt == 4'(NB - 1)) begin
                        cnt   <= '0;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                DONE: begin
                    for (int i = 0; i < 8; i++) begin
                        out_r[i] <= rf_r[i];
                        out_i[i] <= rf_i[i];
                    end
                    valid_o <= 1'b1;
                    busy_o  <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ifft8_core.sv
// tb_ifft8_core: randomized and directed checks of ifft8_core against a stage-by-stage IDFT model.
// Honors IFFT8_SCALE_EN the same way the design does.
module tb_ifft8_core;
    logic clk = 1'b0;
    logic rst;
    logic start;
    logic signed [15:0] xr [8];
    logic signed [15:0] xi [8];
    wire  signed [15:0] yr [8];
    wire  signed [15:0] yi [8];
    wire  valid;
    wire  busy;

    int passed = 0;
    int total  = 0;
    int exp_r [8];
    int exp_i [8];

`ifdef IFFT8_SCALE_EN
    localparam int BASE = 1024;
    localparam int DIAG = 724;
    localparam int FLAT_IN = 8192;
    localparam int FLAT_OUT = 8192;
`else
    localparam int BASE = 8192;
    localparam int DIAG = 5793;
    localparam int FLAT_IN = 16384;
    localparam int FLAT_OUT = 32767;
`endif

    always #5 clk = ~clk;

    ifft8_core dut (
        .clk(clk), .rst(rst), .start_i(start),
        .X_0_R_i(xr[0]), .X_0_I_i(xi[0]), .X_1_R_i(xr[1]), .X_1_I_i(xi[1]),
        .X_2_R_i(xr[2]), .X_2_I_i(xi[2]), .X_3_R_i(xr[3]), .X_3_I_i(xi[3]),
        .X_4_R_i(xr[4]), .X_4_I_i(xi[4]), .X_5_R_i(xr[5]), .X_5_I_i(xi[5]),
        .X_6_R_i(xr[6]), .X_6_I_i(xi[6]), .X_7_R_i(xr[7]), .X_7_I_i(xi[7]),
        .x_0_R_o(yr[0]), .x_0_I_o(yi[0]), .x_1_R_o(yr[1]), .x_1_I_o(yi[1]),
        .x_2_R_o(yr[2]), .x_2_I_o(yi[2]), .x_3_R_o(yr[3]), .x_3_I_o(yi[3]),
        .x_4_R_o(yr[4]), .x_4_I_o(yi[4]), .x_5_R_o(yr[5]), .x_5_I_o(yi[5]),
        .x_6_R_o(yr[6]), .x_6_I_o(yi[6]), .x_7_R_o(yr[7]), .x_7_I_o(yi[7]),
        .valid_o(valid), .busy_o(busy)
    );

    function automatic int sat16(input int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    // Reference IDFT: three radix-2 passes over a bit-reversed copy, Q1.14 truncating products
    task automatic model();
        int ar [8];
        int ai [8];
        int wr [4];
        int wi [4];
        int h, m, p, q, tr, ti, ur, ui, vr, vi;
        longint pre, pim;
        wr = '{16384, 11585, 0, -11585};
        wi = '{0, 11585, 16384, 11585};
        for (int i = 0; i < 8; i++) begin
            p = ((i & 1) << 2) | (i & 2) | ((i >> 2) & 1);
            ar[i] = xr[p];
            ai[i] = xi[p];
        end
        for (int s = 0; s < 3; s++) begin
            h = 1 << s;
            for (int g = 0; g < 8; g += 2 * h) begin
                for (int k = 0; k < h; k++) begin
                    m = k << (2 - s);
                    p = g + k;
                    q = p + h;
                    pre = longint'(ar[q]) * wr[m] - longint'(ai[q]) * wi[m];
                    pim = longint'(ar[q]) * wi[m] + longint'(ai[q]) * wr[m];
                    tr = int'(pre >>> 14);
                    ti = int'(pim >>> 14);
                    ur = ar[p] + tr;  ui = ai[p] + ti;
                    vr = ar[p] - tr;  vi = ai[p] - ti;
`ifdef IFFT8_SCALE_EN
                    ur = ur >>> 1;  ui = ui >>> 1;
                    vr = vr >>> 1;  vi = vi >>> 1;
`endif
                    ar[p] = sat16(ur);  ai[p] = sat16(ui);
                    ar[q] = sat16(vr);  ai[q] = sat16(vi);
                end
            end
        end
        for (int n = 0; n < 8; n++) begin
            exp_r[n] = ar[n];
            exp_i[n] = ai[n];
        end
    endtask

    task automatic rand_inputs(input int amp);
        for (int i = 0; i < 8; i++) begin
            xr[i] = 16'(int'($urandom_range(0, 2 * amp)) - amp);
            xi[i] = 16'(int'($urandom_range(0, 2 * amp)) - amp);
        end
    endtask

    task automatic launch();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Clocks until valid, counting the first edge after the start edge as 1; 0 on timeout
    task automatic wait_valid(output int lat);
        lat = 0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            if (valid === 1'b1) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            xr[i] = '0;
            xi[i] = '0;
        end
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (valid !== 1'b0) $display("FAIL reset_valid got %b want 0", valid);
        else passed++;
        total++;
        if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy);
        else passed++;
        for (int n = 0; n < 8; n++) begin
            total++;
            if (yr[n] !== 16'sd0 || yi[n] !== 16'sd0)
                $display("FAIL reset_out x%0d got (%0d,%0d) want (0,0)", n, yr[n], yi[n]);
            else passed++;
        end
        rst = 1'b1;
    endtask

    task automatic test_directed();
        int lat, dr, di;
        int want_r [8];
        int want_i [8];
        bit chk [8];
        for (int v = 0; v < 3; v++) begin
            for (int i = 0; i < 8; i++) begin
                xr[i] = '0;  xi[i] = '0;
                want_r[i] = 0;  want_i[i] = 0;  chk[i] = 1'b1;
            end
            if (v == 0) begin
                xr[0] = 16'sd8192;
                for (int i = 0; i < 8; i++) want_r[i] = BASE;
            end else if (v == 1) begin
                for (int i = 0; i < 8; i++) xr[i] = 16'(FLAT_IN);
                want_r[0] = FLAT_OUT;
            end else begin
                xr[1] = 16'sd8192;
                want_r[0] = BASE;  want_i[2] = BASE;
                want_r[4] = -BASE; want_i[6] = -BASE;
                chk[1] = 1'b0;  chk[3] = 1'b0;  chk[5] = 1'b0;  chk[7] = 1'b0;
            end
            launch();
            total++;
            if (busy !== 1'b1) $display("FAIL dir%0d_busy got %b want 1", v, busy);
            else passed++;
            wait_valid(lat);
            total++;
            if (lat != 13) $display("FAIL dir%0d_latency got %0d want 13", v, lat);
            else passed++;
            total++;
            if (busy !== 1'b0) $display("FAIL dir%0d_busy_done got %b want 0", v, busy);
            else passed++;
            for (int n = 0; n < 8; n++) begin
                if (chk[n]) begin
                    total++;
                    if (yr[n] !== 16'(want_r[n]) || yi[n] !== 16'(want_i[n]))
                        $display("FAIL dir%0d_x%0d got (%0d,%0d) want (%0d,%0d)",
                                 v, n, yr[n], yi[n], want_r[n], want_i[n]);
                    else passed++;
                end
            end
            if (v == 2) begin
                dr = int'(yr[1]) - DIAG;
                di = int'(yi[1]) - DIAG;
                total++;
                if (dr > 1 || dr < -1 || di > 1 || di < -1)
                    $display("FAIL dir2_x1 got (%0d,%0d) want (%0d,%0d)+-1", yr[1], yi[1], DIAG, DIAG);
                else passed++;
            end
        end
    endtask

    task automatic test_random();
        int lat;
        for (int t = 0; t < 24; t++) begin
            rand_inputs((t % 3 == 0) ? 32767 : ((t % 3 == 1) ? 16384 : 2048));
            model();
            launch();
            rand_inputs(32767);
            wait_valid(lat);
            total++;
            if (lat != 13) $display("FAIL rand%0d_latency got %0d want 13", t, lat);
            else passed++;
            for (int n = 0; n < 8; n++) begin
                total++;
                if (yr[n] !== 16'(exp_r[n]) || yi[n] !== 16'(exp_i[n]))
                    $display("FAIL rand%0d_x%0d got (%0d,%0d) want (%0d,%0d)",
                             t, n, yr[n], yi[n], exp_r[n], exp_i[n]);
                else passed++;
            end
            @(posedge clk);
            #1;
            total++;
            if (valid !== 1'b0) $display("FAIL rand%0d_pulse got %b want 0", t, valid);
            else passed++;
        end
    endtask

    task automatic test_hold();
        int nv = 0;
        rand_inputs(32767);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (valid === 1'b1) nv++;
        end
        total++;
        if (nv != 0) $display("FAIL hold_valid got %0d pulses want 0", nv);
        else passed++;
        for (int n = 0; n < 8; n++) begin
            total++;
            if (yr[n] !== 16'(exp_r[n]) || yi[n] !== 16'(exp_i[n]))
                $display("FAIL hold_x%0d got (%0d,%0d) want (%0d,%0d)", n, yr[n], yi[n], exp_r[n], exp_i[n]);
            else passed++;
        end
    endtask

    task automatic test_ignore_start();
        int nv = 0;
        int first = -1;
        rand_inputs(16384);
        model();
        launch();
        repeat (5) @(negedge clk);
        start = 1'b1;
        rand_inputs(16384);
        for (int c = 6; c <= 40; c++) begin
            @(posedge clk);
            #1;
            if (c == 6) start = 1'b0;
            if (valid === 1'b1) begin
                nv++;
                if (first < 0) first = c;
            end
        end
        total++;
        if (nv != 1) $display("FAIL ignore_count got %0d want 1", nv);
        else passed++;
        total++;
        if (first != 13) $display("FAIL ignore_latency got %0d want 13", first);
        else passed++;
        for (int n = 0; n < 8; n++) begin
            total++;
            if (yr[n] !== 16'(exp_r[n]) || yi[n] !== 16'(exp_i[n]))
                $display("FAIL ignore_x%0d got (%0d,%0d) want (%0d,%0d)", n, yr[n], yi[n], exp_r[n], exp_i[n]);
            else passed++;
        end
    endtask

    task automatic test_back_to_back();
        int nv = 0;
        int e1 = -1;
        int e2 = -1;
        rand_inputs(32767);
        model();
        @(negedge clk);
        start = 1'b1;
        for (int c = 0; c <= 40; c++) begin
            @(posedge clk);
            #1;
            if (c == 14) start = 1'b0;
            if (valid === 1'b1) begin
                nv++;
                if (nv == 1) e1 = c;
                else if (nv == 2) e2 = c;
            end
        end
        total++;
        if (nv != 2) $display("FAIL b2b_count got %0d want 2", nv);
        else passed++;
        total++;
        if (e1 != 13) $display("FAIL b2b_first got %0d want 13", e1);
        else passed++;
        total++;
        if (e2 - e1 != 14) $display("FAIL b2b_gap got %0d want 14", e2 - e1);
        else passed++;
        for (int n = 0; n < 8; n++) begin
            total++;
            if (yr[n] !== 16'(exp_r[n]) || yi[n] !== 16'(exp_i[n]))
                $display("FAIL b2b_x%0d got (%0d,%0d) want (%0d,%0d)", n, yr[n], yi[n], exp_r[n], exp_i[n]);
            else passed++;
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        rand_inputs(8192);
        launch();
        repeat (6) @(negedge clk);
        #1 rst = 1'b0;
        #1;
        total++;
        if (busy !== 1'b0 || valid !== 1'b0)
            $display("FAIL midrst_ctrl got busy=%b valid=%b want 0 0", busy, valid);
        else passed++;
        for (int n = 0; n < 8; n++) begin
            total++;
            if (yr[n] !== 16'sd0 || yi[n] !== 16'sd0)
                $display("FAIL midrst_x%0d got (%0d,%0d) want (0,0)", n, yr[n], yi[n]);
            else passed++;
        end
        @(negedge clk);
        rand_inputs(32767);
        model();
        rst = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (busy !== 1'b1) $display("FAIL midrst_accept got busy=%b want 1", busy);
        else passed++;
        @(negedge clk);
        start = 1'b0;
        wait_valid(lat);
        total++;
        if (lat != 13) $display("FAIL midrst_latency got %0d want 13", lat);
        else passed++;
        for (int n = 0; n < 8; n++) begin
            total++;
            if (yr[n] !== 16'(exp_r[n]) || yi[n] !== 16'(exp_i[n]))
                $display("FAIL midrst_res_x%0d got (%0d,%0d) want (%0d,%0d)", n, yr[n], yi[n], exp_r[n], exp_i[n]);
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_hold();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
